// File: rtl/alu_register.sv
// alu_register: registered ALU stage with an 8-bit result register whose low
// nibble feeds back as operand B. Single-cycle add/or-reduce/and-reduce/
// concat/shift-left/shift-right/hold, plus a 4-cycle shift-add multiply.
//
// Handshake: Go acts as "valid" and ~Busy as "ready". A request is accepted
// at a rising edge where Go=1 and the machine is IDLE (Busy=0); Data and
// Function are sampled only at that edge. Go while Busy is dropped and not
// queued. Done is a registered one-cycle pulse following every result write.
module alu_register (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Data,
  input  logic [2:0] Function,
  input  logic       Go,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] ALUout
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  b_op;
  logic [4:0]  sum5;
  logic [7:0]  alu_result;

  // Multiply working set: latched operands so feedback cannot disturb them.
  logic [3:0]  multiplicand;
  logic [3:0]  multiplier;
  logic [7:0]  acc;
  logic [1:0]  count;
  logic [7:0]  mul_term;
  logic [7:0]  acc_sum;

  logic        op_write;
  logic [7:0]  op_result;
  logic        mul_start;

  assign b_op = ALUout[3:0];
  assign sum5 = {1'b0, Data} + {1'b0, b_op};
  assign Busy = (state == MUL);

  // Single-cycle function decode against the current feedback operand.
  always_comb begin
    alu_result = ALUout;
    case (Function)
      3'd0: alu_result = {3'b000, sum5};
      3'd1: alu_result = (|{Data, b_op}) ? 8'h01 : 8'h00;
      3'd2: alu_result = (&{Data, b_op}) ? 8'h01 : 8'h00;
      3'd3: alu_result = {Data, b_op};
      3'd5: alu_result = (Data >= 4'd8) ? 8'h00 : ({4'b0000, b_op} << Data);
      3'd6: alu_result = (Data >= 4'd4) ? 8'h00 : ({4'b0000, b_op} >> Data);
      default: alu_result = ALUout;
    endcase
  end

  // Partial product for the current multiplier bit and the running sum.
  always_comb begin
    mul_term = multiplier[count] ? ({4'b0000, multiplicand} << count) : 8'h00;
    acc_sum  = acc + mul_term;
  end

  // FSM next state and write/start strobes.
  always_comb begin
    state_next = state;
    op_write   = 1'b0;
    op_result  = ALUout;
    mul_start  = 1'b0;
    case (state)
      IDLE: begin
        if (Go) begin
          if (Function == 3'd4) begin
            mul_start  = 1'b1;
            state_next = MUL;
          end else begin
            op_write  = 1'b1;
            op_result = alu_result;
          end
        end
      end
      MUL: begin
        if (count == 2'd3) begin
          op_write   = 1'b1;
          op_result  = acc_sum;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Result register, Done pulse and multiply datapath.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ALUout       <= 8'h00;
      Done         <= 1'b0;
      multiplicand <= 4'h0;
      multiplier   <= 4'h0;
      acc          <= 8'h00;
      count        <= 2'd0;
    end else begin
      Done <= op_write;
      if (op_write) ALUout <= op_result;
      if (mul_start) begin
        multiplicand <= Data;
        multiplier   <= b_op;
        acc          <= 8'h00;
        count        <= 2'd0;
      end else if (state == MUL) begin
        acc   <= acc_sum;
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_register.sv
// Directed bench for alu_register: hand-computed vectors for every function,
// multiply timing, Go-while-busy, reset abort and reset-vs-Go priority.
module tb_alu_register;

  logic       Clock;
  logic       Reset;
  logic [3:0] Data;
  logic [2:0] Function;
  logic       Go;
  logic       Busy;
  logic       Done;
  logic [7:0] ALUout;

  int checks = 0;
  int errors = 0;

  alu_register dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Data     (Data),
    .Function (Function),
    .Go       (Go),
    .Busy     (Busy),
    .Done     (Done),
    .ALUout   (ALUout)
  );

  // Clock: 10 time-unit period.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One accepted request: Go high for exactly one edge.
  task automatic do_op(input logic [2:0] f, input logic [3:0] a);
    Function = f;
    Data     = a;
    Go       = 1'b1;
    tick();
    Go       = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [7:0] exp);
    check({tag, "_out"}, ALUout, exp);
    check({tag, "_done"}, {7'b0, Done}, 8'h01);
    check({tag, "_busy"}, {7'b0, Busy}, 8'h00);
  endtask

  initial begin
    int busy_cycles;
    Reset = 1'b1;
    Go = 1'b0;
    Data = 4'h0;
    Function = 3'd0;
    tick();
    tick();
    check("rst_out", ALUout, 8'h00);
    check("rst_busy", {7'b0, Busy}, 8'h00);
    check("rst_done", {7'b0, Done}, 8'h00);
    Reset = 1'b0;

    // Add, including the first Go right after reset release.
    do_op(3'd0, 4'h5);  expect_write("add5", 8'h05);
    do_op(3'd0, 4'hF);  expect_write("add15", 8'h14);
    tick();
    check("idle_done", {7'b0, Done}, 8'h00);
    check("idle_out", ALUout, 8'h14);

    // Build 0x07: concat A=0 with B=4 -> 0x04, then 3+4.
    do_op(3'd3, 4'h0);  expect_write("cat_04", 8'h04);
    do_op(3'd0, 4'h3);  expect_write("add_07", 8'h07);

    // Multiply 15 * 7 = 0x69, with a Go pulse during Busy.
    do_op(3'd4, 4'hF);
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (Busy) busy_cycles++;
      check("mul_hold_out", ALUout, 8'h07);
      check("mul_hold_done", {7'b0, Done}, 8'h00);
      if (i == 1) begin
        Go = 1'b1; Function = 3'd0; Data = 4'h1;
      end
      tick();
      Go = 1'b0;
    end
    check("mul_busy_cycles", 8'(busy_cycles), 8'd4);
    expect_write("mul_result", 8'h69);
    tick();
    check("mul_no_extra_done", {7'b0, Done}, 8'h00);
    check("mul_no_queue_out", ALUout, 8'h69);
    check("mul_no_queue_busy", {7'b0, Busy}, 8'h00);

    // Shifts from 0x09.
    do_op(3'd3, 4'h0);  expect_write("cat_09", 8'h09);
    do_op(3'd5, 4'h3);  expect_write("shl3", 8'h48);
    do_op(3'd6, 4'h2);  expect_write("shr2", 8'h02);
    do_op(3'd5, 4'h9);  expect_write("shl9", 8'h00);

    // Reductions, concat and carry.
    do_op(3'd1, 4'h0);  expect_write("or_zero", 8'h00);
    do_op(3'd1, 4'h4);  expect_write("or_one", 8'h01);
    do_op(3'd0, 4'hE);  expect_write("add_0f", 8'h0F);
    do_op(3'd2, 4'hF);  expect_write("and_all", 8'h01);
    do_op(3'd3, 4'hA);  expect_write("cat_a1", 8'hA1);
    do_op(3'd0, 4'hF);  expect_write("add_carry", 8'h10);
    do_op(3'd2, 4'hF);  expect_write("and_part", 8'h00);

    // Hold and wide right shift.
    do_op(3'd0, 4'hC);  expect_write("add_0c", 8'h0C);
    do_op(3'd3, 4'h5);  expect_write("cat_5c", 8'h5C);
    do_op(3'd7, 4'h3);  expect_write("hold", 8'h5C);
    do_op(3'd6, 4'h4);  expect_write("shr4", 8'h00);

    // Go held high: one op per edge, chained through feedback.
    Function = 3'd0; Data = 4'h1; Go = 1'b1;
    tick(); expect_write("chain1", 8'h01);
    tick(); expect_write("chain2", 8'h02);
    tick(); expect_write("chain3", 8'h03);
    Go = 1'b0;

    // Reset during the second MUL cycle aborts the multiply.
    do_op(3'd4, 4'hF);
    tick();
    check("abort_busy_pre", {7'b0, Busy}, 8'h01);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_out", ALUout, 8'h00);
    check("abort_busy", {7'b0, Busy}, 8'h00);
    check("abort_done", {7'b0, Done}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_quiet_done", {7'b0, Done}, 8'h00);
      check("abort_quiet_out", ALUout, 8'h00);
    end

    // Reset wins over Go at the same edge.
    do_op(3'd0, 4'h6);  expect_write("add_06", 8'h06);
    Reset = 1'b1; Go = 1'b1; Function = 3'd0; Data = 4'h3;
    tick();
    check("prio_out", ALUout, 8'h00);
    check("prio_done", {7'b0, Done}, 8'h00);
    Function = 3'd4;
    tick();
    check("prio_mul_busy", {7'b0, Busy}, 8'h00);
    Reset = 1'b0; Go = 1'b0;
    tick();
    check("prio_after_busy", {7'b0, Busy}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_register.md
# alu_register

Registered, multi-cycle ALU stage. It sits directly downstream of the 4-bit combinational ALU and its ripple-carry adder. An 8-bit result register captures each operation's result, and the register's low nibble feeds back as operand B. The four ALU functions are kept and extended with a sequential shift-add multiply, two shifts and a hold; `Go`/`Busy`/`Done` form the handshake.

## Interface
- No parameters; widths fixed (4-bit operands, 8-bit result).
- `Clock  input  1` — rising-edge clock; all state changes on this edge.
- `Reset  input  1` — synchronous, active-high reset.
- `Data  input  4` — operand A; sampled only at an accepted `Go`.
- `Function  input  3` — operation select; sampled only at an accepted `Go`.
- `Go  input  1` — start request; accepted at an edge where `Go`=1 and state is IDLE.
- `Busy  output  1` — 1 while a multiply is in progress (state MUL).
- `Done  output  1` — registered one-cycle pulse after each result write (including hold).
- `ALUout  output  8` — result register; `ALUout[3:0]` is operand B.

## Operation
- B is always `ALUout[3:0]` as it stands at the accepting edge.
- Function codes, where the result is written to `ALUout`:
  - 0: `{3'b000, A+B}`, a 5-bit sum (carry in bit 4).
  - 1: `8'h01` if `|{A,B}`, else `8'h00`.
  - 2: `8'h01` if `&{A,B}`, else `8'h00`.
  - 3: `{A,B}`.
  - 4: `A*B`, 8-bit unsigned product computed by multi-cycle shift-add.
  - 5: `({4'b0,B} << A)` truncated to 8 bits; A ≥ 8 gives `8'h00`.
  - 6: `({4'b0,B} >> A)`; A ≥ 4 gives `8'h00`.
  - 7: hold; `ALUout` is unchanged.
- State machine: IDLE, MUL.
  - IDLE, with `Go` and Function≠4: result written at the same edge; stay IDLE.
  - IDLE, with `Go` and Function=4: latch multiplicand←A, multiplier←B, accumulator←0, count←0; go to MUL.
  - MUL: each edge adds `multiplicand<<count` to the accumulator if `multiplier[count]`=1, then increments count.
  - MUL exit: at the edge where count=3, write the final accumulator to `ALUout` and return to IDLE.
- `ALUout` is not modified during MUL until the final write. Operands are latched copies, so feedback does not disturb the multiply.
- `Go` while in MUL is ignored and is not queued. `Data` and `Function` changes during MUL have no effect.
- `Done` is set at each write edge (every accepted non-multiply op, and the final MUL edge) and cleared at every other edge.
- Reset, including mid-multiply, sets `ALUout`=`8'h00`, state=IDLE, `Busy`=0, `Done`=0, accumulator=0 and count=0.
  - The aborted multiply produces no later write and no `Done`.
  - Reset has priority over `Go` at the same edge.

## Timing
- Single-cycle ops: `Go` is sampled at edge k; `ALUout` is valid after edge k; `Done`=1 during cycle k→k+1.
- Multiply: accepted at edge k; `Busy`=1 from after edge k until edge k+4.
  - The product is visible after edge k+4, with `Done`=1 in that cycle and `Busy`=0.
  - Latency is 4 cycles; throughput is one multiply per 5 edges when `Go` is held high.
- With `Go` held high in IDLE, a new op is accepted every edge, each using the previous result as B.
- `Busy` is decoded from the registered state, so it is glitch-free; `Done` is a flop output.
- After reset deassertion, the first acceptable `Go` is at the next edge.

## Test plan
- **Add:**
  - Reset, then Go F=0 A=5 → `ALUout`=`0x05`, with a `Done` pulse.
  - Then Go F=0 A=`0xF` → `0x14` (15+5).
- **Multiply:**
  - With `ALUout`=`0x07`, Go F=4 A=`0xF` → `Busy` high for exactly 4 cycles; `ALUout` stays `0x07` until edge k+4, then becomes `0x69`, with one `Done`.
  - `Go` pulsed during `Busy` → ignored; no extra `Done`.
- **Shifts:**
  - `ALUout`=`0x09`, Go F=5 A=3 → `0x48`.
  - Then Go F=6 A=2 → `0x02` (B=8).
  - Then Go F=5 A=9 → `0x00`.
- **Reductions and concat:**
  - From `0x00`: F=1 A=0 → `0x00`; then F=1 A=4 → `0x01`.
  - From `0x0F`: F=2 A=`0xF` → `0x01`.
  - From `0x01`: F=3 A=`0xA` → `0xA1`.
- **Reset mid-multiply:** Reset asserted on the 2nd MUL cycle → next edge `ALUout`=`0x00`, `Busy`=0; no `Done` over the following 5 cycles.
- **Hold and priority:**
  - F=7 with `ALUout`=`0x5C` → stays `0x5C`, `Done` pulses.
  - Reset and Go at the same edge → reset wins; `Done`=0.
